// File: rtl/ram_master_ctrl.sv
// Command-driven master for a single-port RAM: single-word WRITE/READ plus
// whole-array FILL (seed+i) and SUM sweeps, each ending in a one-cycle response.
module ram_master_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [2:0]        dbg_state
);

    // Handshake: a command is accepted at a posedge where cmd_valid & cmd_ready;
    // cmd_ready is only offered in IDLE outside reset. Responses have no ready.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FILL  = 3'd3,
        S_SUM   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] rsp_q;
    logic [3:0]        idx_q;
    logic              hs;
    logic              last_idx;

    assign hs        = cmd_valid & cmd_ready;
    assign last_idx  = (idx_q == 4'hF);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        state_n     = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    case (cmd_op)
                        2'b00:   state_n = S_WRITE;
                        2'b01:   state_n = S_READ;
                        2'b10:   state_n = S_FILL;
                        default: state_n = S_SUM;
                    endcase
                end
            end
            S_WRITE: begin
                mem_addr    = addr_q;
                mem_data_in = data_q;
                mem_we      = !rst;
                state_n     = S_RESP;
            end
            S_READ: begin
                mem_addr = addr_q;
                state_n  = S_RESP;
            end
            S_FILL: begin
                mem_addr    = ADDR_W'(idx_q);
                mem_data_in = data_q + DATA_W'(idx_q);
                mem_we      = !rst;
                if (last_idx) state_n = S_RESP;
            end
            S_SUM: begin
                mem_addr = ADDR_W'(idx_q);
                if (last_idx) state_n = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_q;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            data_q <= '0;
            acc_q  <= '0;
            rsp_q  <= '0;
            idx_q  <= '0;
        end else begin
            state <= state_n;
            if (hs) begin
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                idx_q  <= '0;
                acc_q  <= '0;
            end
            case (state)
                S_WRITE: rsp_q <= data_q;
                S_READ:  rsp_q <= mem_data_out;
                S_FILL: begin
                    idx_q <= idx_q + 4'd1;
                    if (last_idx) rsp_q <= data_q;
                end
                S_SUM: begin
                    idx_q <= idx_q + 4'd1;
                    acc_q <= acc_q + mem_data_out;
                    // Final word folds straight into the response register.
                    if (last_idx) rsp_q <= acc_q + mem_data_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master_ctrl.sv
// Directed bench for ram_master_ctrl with a behavioural 16x8 RAM model.
module tb_ram_master_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;
    logic [2:0]        dbg_state;

    logic [DATA_W-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    ram_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out), .dbg_state(dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Leaves the bench 1ns after the accepting edge N (inside cycle N+1).
    task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready got %b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns the number of cycles from N+1 to the response cycle (inclusive).
    task automatic run_op(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                          output logic [7:0] rdata, output int lat, output logic busy_ok);
        issue(op, addr, data);
        lat     = -1;
        rdata   = 'x;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                rdata = rsp_data;
                lat   = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", cmd_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy, mem_we} !== 4'b1000) begin
            errors++; $display("FAIL rst_flags: ready/rsp/busy/we got %b expected 1000", {cmd_ready, rsp_valid, busy, mem_we});
        end
        checks++;
        if ({rsp_data, mem_addr, mem_data_in} !== 20'h0) begin
            errors++; $display("FAIL rst_values: rsp_data/addr/din got %h expected 0", {rsp_data, mem_addr, mem_data_in});
        end
    endtask

    task automatic test_write_read;
        issue(2'b00, 4'd5, 8'hA3);
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_data_in, busy, cmd_ready} !== {1'b1, 4'd5, 8'hA3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL write_cycle: we/addr/din/busy/ready got %b %h %h %b %b expected 1 5 a3 1 0",
                                mem_we, mem_addr, mem_data_in, busy, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, mem_we, mem_addr} !== {1'b1, 8'hA3, 1'b0, 4'd0}) begin
            errors++; $display("FAIL write_resp: rsp/data/we/addr got %b %h %b %h expected 1 a3 0 0",
                                rsp_valid, rsp_data, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL write_idle: rsp/ready/busy got %b expected 010", {rsp_valid, cmd_ready, busy});
        end
        checks++;
        if (mem[5] !== 8'hA3) begin errors++; $display("FAIL write_mem: mem[5] got %h expected a3", mem[5]); end

        issue(2'b01, 4'd5, 8'h00);
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, busy} !== {1'b0, 4'd5, 1'b1}) begin
            errors++; $display("FAIL read_cycle: we/addr/busy got %b %h %b expected 0 5 1", mem_we, mem_addr, busy);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'hA3}) begin
            errors++; $display("FAIL read_resp: rsp/data got %b %h expected 1 a3", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_fill;
        int bad = 0;
        issue(2'b10, 4'd0, 8'hF8);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_addr, mem_data_in, busy, rsp_valid} !== {1'b1, 4'(i), 8'hF8 + 8'(i), 1'b1, 1'b0}) begin
                errors++; bad++;
                $display("FAIL fill_step%0d: we/addr/din/busy/rsp got %b %h %h %b %b expected 1 %h %h 1 0",
                         i, mem_we, mem_addr, mem_data_in, busy, rsp_valid, 4'(i), 8'hF8 + 8'(i));
            end
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, mem_we} !== {1'b1, 8'hF8, 1'b0}) begin
            errors++; $display("FAIL fill_resp: rsp/data/we got %b %h %b expected 1 f8 0", rsp_valid, rsp_data, mem_we);
        end
        checks++;
        if ({mem[0], mem[7], mem[8], mem[15]} !== 32'hF8FF0007) begin
            errors++; $display("FAIL fill_mem: mem[0,7,8,15] got %h expected f8ff0007", {mem[0], mem[7], mem[8], mem[15]});
        end
    endtask

    task automatic test_sum;
        logic [7:0] r; int lat; logic bok;
        run_op(2'b10, 4'd0, 8'h00, r, lat, bok);
        checks++;
        if (lat !== 17 || r !== 8'h00) begin errors++; $display("FAIL sum_prefill: lat/data got %0d %h expected 17 00", lat, r); end
        run_op(2'b11, 4'd0, 8'h00, r, lat, bok);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL sum_latency: got %0d expected 17", lat); end
        checks++;
        if (r !== 8'h78) begin errors++; $display("FAIL sum_value: got %h expected 78", r); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL sum_busy: busy_high got %b expected 1", bok); end
    endtask

    task automatic test_sum_wrap;
        logic [7:0] r; int lat; logic bok;
        for (int a = 0; a < 16; a++) run_op(2'b00, 4'(a), 8'hFF, r, lat, bok);
        run_op(2'b11, 4'd0, 8'h00, r, lat, bok);
        checks++;
        if (lat !== 17 || r !== 8'hF0) begin errors++; $display("FAIL sum_wrap: lat/data got %0d %h expected 17 f0", lat, r); end
    endtask

    task automatic test_back_to_back;
        int hs = 0;
        int rsp = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'd3; cmd_data = 8'h11;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({cmd_ready, busy, rsp_valid} !== {(k % 3 == 0), (k % 3 != 0), (k % 3 == 2)}) begin
                errors++; $display("FAIL b2b_cycle%0d: ready/busy/rsp got %b expected %b", k,
                                   {cmd_ready, busy, rsp_valid}, {(k % 3 == 0), (k % 3 != 0), (k % 3 == 2)});
            end
            if (cmd_ready) hs++;
            if (rsp_valid) rsp++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (hs !== 4 || rsp !== 4) begin errors++; $display("FAIL b2b_count: hs/rsp got %0d %0d expected 4 4", hs, rsp); end
    endtask

    task automatic test_reset_mid_fill;
        logic [7:0] r; int lat; logic bok;
        int rsp_seen = 0;
        run_op(2'b10, 4'd0, 8'h40, r, lat, bok);
        issue(2'b10, 4'd0, 8'h10);
        repeat (7) @(negedge clk);
        checks++;
        if (mem_addr !== 4'd6) begin errors++; $display("FAIL midrst_index: mem_addr got %h expected 6", mem_addr); end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_gate: mem_we got %b expected 0", mem_we); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL midrst_idle: ready/busy/rsp got %b expected 100", {cmd_ready, busy, rsp_valid});
        end
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: pulses got %0d expected 0", rsp_seen); end
        checks++;
        if ({mem[0], mem[5], mem[6], mem[7]} !== 32'h10154647) begin
            errors++; $display("FAIL midrst_mem: mem[0,5,6,7] got %h expected 10154647", {mem[0], mem[5], mem[6], mem[7]});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_sum();
        test_sum_wrap();
        test_back_to_back();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_master_ctrl.md
RAM_MASTER_CTRL -- requirements
Module: ram_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, controller can accept a command.
REQ-007 SHALL have port cmd_op, input, 2, opcode: 00 WRITE, 01 READ, 10 FILL, 11 SUM.
REQ-008 SHALL have port cmd_addr, input, ADDR_W, target address (WRITE/READ only).
REQ-009 SHALL have port cmd_data, input, DATA_W, write data (WRITE) or seed (FILL).
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_data, output, DATA_W, result, valid only while rsp_valid=1.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port mem_addr, output, ADDR_W, RAM address.
REQ-014 SHALL have port mem_data_in, output, DATA_W, RAM write data.
REQ-015 SHALL have port mem_we, output, 1, RAM write enable; RAM writes on posedge clk when high.
REQ-016 SHALL have port mem_data_out, input, DATA_W, RAM combinational read data for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, FILL, SUM, RESP.
REQ-018 SHALL drive cmd_ready=1 only in IDLE with rst=0; handshake = cmd_valid & cmd_ready at a posedge.
REQ-019 SHALL on handshake at edge N latch cmd_op/cmd_addr/cmd_data and enter the op state for cycle N+1; cmd inputs ignored otherwise.
REQ-020 WRITE SHALL for exactly cycle N+1 drive mem_addr=addr, mem_data_in=data, mem_we=1; then RESP.
REQ-021 READ SHALL for cycle N+1 drive mem_addr=addr, mem_we=0, capture mem_data_out at end of that cycle; then RESP.
REQ-022 FILL SHALL over cycles N+1..N+16 drive mem_addr=i (i=0..15), mem_data_in=(seed+i) mod 2^DATA_W, mem_we=1; then RESP.
REQ-023 SUM SHALL over cycles N+1..N+16 drive mem_addr=i, mem_we=0, accumulate mem_data_out mod 2^DATA_W (accumulator cleared on handshake); then RESP.
REQ-024 SHALL use a 4-bit index counter; op ends when index=15 is processed, no wrap to 0 is issued.
REQ-025 RESP SHALL last one cycle (N+2 for WRITE/READ, N+17 for FILL/SUM) with rsp_valid=1; then IDLE.
REQ-026 rsp_data SHALL be: WRITE → written data; READ → read value; FILL → seed; SUM → 8-bit sum.
REQ-027 SHALL not support response backpressure; rsp_valid is a pulse regardless of consumer.
REQ-028 Outside WRITE/FILL cycles SHALL hold mem_we=0; in IDLE/RESP, mem_addr=0 and mem_data_in=0.
REQ-029 Back-to-back: next handshake earliest at end of RESP+1 cycle (IDLE), i.e. WRITE→WRITE period 3 cycles.
REQ-030 busy SHALL equal not(IDLE); cmd_ready SHALL never be high while busy=1.

Reset
REQ-031 rst high at a posedge SHALL force IDLE, clear index, accumulator, latched command, rsp_data.
REQ-032 mem_we SHALL be gated by !rst so no RAM write occurs at the reset edge, even mid-FILL/WRITE.
REQ-033 After reset: cmd_ready=1 (once rst=0), rsp_valid=0, rsp_data=0, busy=0, mem_we=0, mem_addr=0, mem_data_in=0.
REQ-034 Reset mid-operation SHALL abort without a response pulse; already-written FILL words remain.

Verification
REQ-035 WRITE addr=5 data=0xA3, then READ addr=5 → first rsp_data=0xA3 at N+2; second rsp_data=0xA3, mem_we=0 during read.
REQ-036 FILL seed=0xF8 → 16 writes, mem[0]=0xF8, mem[7]=0xFF, mem[8]=0x00, mem[15]=0x07; rsp at N+17, rsp_data=0xF8.
REQ-037 FILL seed=0x00 then SUM → rsp_data=0x78 (0+..+15=120) at N+17; busy high N+1..N+17.
REQ-038 cmd_valid held high continuously with WRITEs → cmd_ready low during WRITE and RESP, exactly one handshake per 3 cycles.
REQ-039 rst pulsed in FILL cycle with i=6 → no write to addr 6, mem[0..5] written, no rsp_valid, cmd_ready=1 next cycle.
REQ-040 SUM over RAM all 0xFF → rsp_data=0xF0 (4080 mod 256), verifying 8-bit wrap.
